// File: rtl/vend_ctrl_sequencer_pkg.sv
// Shared encodings for the vending controller: FSM states, coin-acceptor codes
// and change-return codes.
package vend_ctrl_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_5    = 2'b01;
    localparam logic [1:0] CHG_10   = 2'b10;

    // Credit units carried by one coin code; the invalid code carries none.
    function automatic logic [1:0] coin_units(input logic [1:0] coin);
        case (coin)
            COIN_5:  return 2'd1;
            COIN_10: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_ctrl_sequencer_inventory.sv
// Per-slot stock counters with decrement (sale), increment (refund) and reload
// (restock) requests; sold_out is registered alongside the counters.
module vend_ctrl_sequencer_inventory
    import vend_ctrl_sequencer_pkg::*;
#(
    parameter int N_SLOTS    = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8,
    parameter int SW         = $clog2(N_SLOTS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec,
    input  logic [SW-1:0]      dec_id,
    input  logic               inc,
    input  logic [SW-1:0]      inc_id,
    input  logic               reload,
    input  logic [SW-1:0]      reload_id,
    output logic [N_SLOTS-1:0] sold_out
);

    localparam logic [STOCK_W-1:0] INIT_S = STOCK_W'(INIT_STOCK);

    logic [STOCK_W-1:0] stock [N_SLOTS];

    // Reload wins over a same-cycle sale; counters saturate at both ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                stock[i] <= INIT_S;
            end
            sold_out <= {N_SLOTS{INIT_S == '0}};
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (reload && reload_id == SW'(i)) begin
                    stock[i]    <= INIT_S;
                    sold_out[i] <= (INIT_S == '0);
                end else if (dec && dec_id == SW'(i) && stock[i] != '0) begin
                    stock[i]    <= stock[i] - 1'b1;
                    sold_out[i] <= (stock[i] == STOCK_W'(1));
                end else if (inc && inc_id == SW'(i) && stock[i] != '1) begin
                    stock[i]    <= stock[i] + 1'b1;
                    sold_out[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/vend_ctrl_sequencer.sv
// Vending controller: coin credit, selection validation, dispense req/ack with
// timeout refund, and one-coin-per-cycle change return.
module vend_ctrl_sequencer
    import vend_ctrl_sequencer_pkg::*;
#(
    parameter int                         N_SLOTS    = 4,
    parameter int                         PRICE_W    = 4,
    parameter logic [N_SLOTS*PRICE_W-1:0] PRICES     = {4'd4, 4'd3, 4'd2, 4'd3},
    parameter int                         CREDIT_W   = 5,
    parameter int                         MAX_CREDIT = 20,
    parameter int                         STOCK_W    = 4,
    parameter int                         INIT_STOCK = 8,
    parameter int                         TIMEOUT    = 15,
    localparam int                        SW         = $clog2(N_SLOTS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          in,
    input  logic                sel_valid,
    input  logic [SW-1:0]       sel_id,
    input  logic                cancel,
    input  logic                disp_ack,
    input  logic                restock,
    input  logic [SW-1:0]       restock_id,
    output logic                disp_req,
    output logic [SW-1:0]       disp_id,
    output logic [1:0]          change,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_SLOTS-1:0]  sold_out,
    output logic                coin_reject,
    output logic                sel_reject,
    output logic                fault
);

    localparam int                TW    = $clog2(TIMEOUT + 1);
    localparam logic [CREDIT_W:0] MAXC1 = (CREDIT_W + 1)'(MAX_CREDIT);

    generate
        if (MAX_CREDIT >= 2**CREDIT_W - 2) begin : g_credit_range
            $error("MAX_CREDIT must be below 2**CREDIT_W-2");
        end
    endgenerate

    function automatic logic [PRICE_W-1:0] price_of(input logic [SW-1:0] id);
        logic [PRICE_W-1:0] p;
        p = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (id == SW'(i)) p = PRICES[i*PRICE_W +: PRICE_W];
        end
        return p;
    endfunction

    state_t              state;
    logic [TW-1:0]       timer;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_rej;
    logic [CREDIT_W-1:0] credit_in;
    logic [PRICE_W-1:0]  sel_price;
    logic [PRICE_W-1:0]  disp_price;
    logic                idle_like;
    logic                take_cancel;
    logic                sel_go;
    logic                sel_ok;
    logic                accept;
    logic                timeout_hit;
    logic                inv_reload;

    // Coin sum is one bit wider than credit so the overflow compare cannot wrap.
    always_comb begin
        coin_sum    = {1'b0, credit} + {{(CREDIT_W-1){1'b0}}, coin_units(in)};
        coin_rej    = (in == COIN_BAD) || (coin_sum > MAXC1);
        credit_in   = coin_rej ? credit : coin_sum[CREDIT_W-1:0];
        sel_price   = price_of(sel_id);
        disp_price  = price_of(disp_id);
        idle_like   = (state == ST_IDLE) || (state == ST_CREDIT);
        take_cancel = idle_like && cancel && (credit != '0);
        sel_go      = idle_like && sel_valid && !cancel;
        sel_ok      = (int'(sel_id) < N_SLOTS) && !sold_out[sel_id]
                      && (credit >= CREDIT_W'(sel_price));
        accept      = sel_go && sel_ok;
        timeout_hit = (state == ST_DISPENSE) && !disp_ack && (timer == TW'(TIMEOUT - 1));
        inv_reload  = (state == ST_IDLE) && restock;
    end

    vend_ctrl_sequencer_inventory #(
        .N_SLOTS   (N_SLOTS),
        .STOCK_W   (STOCK_W),
        .INIT_STOCK(INIT_STOCK),
        .SW        (SW)
    ) u_inventory (
        .clk      (clk),
        .rst      (rst),
        .dec      (accept),
        .dec_id   (sel_id),
        .inc      (timeout_hit),
        .inc_id   (disp_id),
        .reload   (inv_reload),
        .reload_id(restock_id),
        .sold_out (sold_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            credit      <= '0;
            disp_req    <= 1'b0;
            disp_id     <= '0;
            change      <= CHG_NONE;
            coin_reject <= 1'b0;
            sel_reject  <= 1'b0;
            fault       <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            sel_reject  <= 1'b0;
            change      <= CHG_NONE;
            case (state)
                ST_IDLE, ST_CREDIT: begin
                    coin_reject <= coin_rej;
                    if (take_cancel) begin
                        credit <= credit_in;
                        state  <= ST_CHANGE;
                    end else if (accept) begin
                        // Selection was judged on pre-coin credit; a same-cycle coin still lands.
                        credit   <= credit_in - CREDIT_W'(sel_price);
                        disp_req <= 1'b1;
                        disp_id  <= sel_id;
                        timer    <= '0;
                        state    <= ST_DISPENSE;
                    end else begin
                        sel_reject <= sel_go;
                        credit     <= credit_in;
                        state      <= (credit_in != '0) ? ST_CREDIT : ST_IDLE;
                    end
                end
                ST_DISPENSE: begin
                    coin_reject <= (in != COIN_NONE);
                    if (disp_ack) begin
                        disp_req <= 1'b0;
                        state    <= (credit != '0) ? ST_CHANGE : ST_IDLE;
                    end else if (timeout_hit) begin
                        disp_req <= 1'b0;
                        fault    <= 1'b1;
                        credit   <= credit + CREDIT_W'(disp_price);
                        state    <= ST_CHANGE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_CHANGE: begin
                    coin_reject <= (in != COIN_NONE);
                    if (credit == '0) begin
                        state <= ST_IDLE;
                    end else if (credit >= CREDIT_W'(2)) begin
                        change <= CHG_10;
                        credit <= credit - CREDIT_W'(2);
                    end else begin
                        change <= CHG_5;
                        credit <= credit - CREDIT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
